// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled 8N1 deframer with held-ready output.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err flag.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clken,
    input  logic                 Rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rdy,
    output logic                 Rx_busy,
    output logic                 frame_err,
    output logic                 overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t               state, state_n;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [SW-1:0]        scnt, scnt_n;
    logic [BW-1:0]        bcnt, bcnt_n;
    logic [DATA_BITS-1:0] sreg, sreg_n;
    logic                 good;
    logic                 ferr;
    logic                 par_ok;

`ifdef UART_RX_PARITY_EN
    logic perr, perr_n;
    logic pfail;
    assign par_ok = !perr;
`else
    assign par_ok = 1'b1;
`endif

    assign rx_s    = sync[1];
    assign Rx_busy = (state != IDLE);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            state <= IDLE;
            scnt  <= '0;
            bcnt  <= '0;
            sreg  <= '0;
`ifdef UART_RX_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            sync  <= {sync[0], Rx};
            state <= state_n;
            scnt  <= scnt_n;
            bcnt  <= bcnt_n;
            sreg  <= sreg_n;
`ifdef UART_RX_PARITY_EN
            perr  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        scnt_n  = scnt;
        bcnt_n  = bcnt;
        sreg_n  = sreg;
        good    = 1'b0;
        ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n  = perr;
        pfail   = 1'b0;
`endif
        if (clken) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_n = START;
                        scnt_n  = '0;
                    end
                end
                START: begin
                    if (scnt == HALF) begin
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            scnt_n  = '0;
                            bcnt_n  = '0;
`ifdef UART_RX_PARITY_EN
                            perr_n  = 1'b0;
`endif
                        end
                    end else begin
                        scnt_n = scnt + 1'b1;
                    end
                end
                DATA: begin
                    // scnt wraps to 0 at FULL since OVERSAMPLE is a power of two
                    scnt_n = scnt + 1'b1;
                    if (scnt == FULL) begin
                        sreg_n = {rx_s, sreg[DATA_BITS-1:1]};
                        bcnt_n = bcnt + 1'b1;
                        if (bcnt == LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    scnt_n = scnt + 1'b1;
                    if (scnt == FULL) begin
                        perr_n  = rx_s ^ (^sreg);
                        state_n = STOP;
                    end
                end
`endif
                STOP: begin
                    scnt_n = scnt + 1'b1;
                    if (scnt == FULL) begin
                        state_n = IDLE;
                        ferr    = !rx_s;
                        good    = rx_s && par_ok;
`ifdef UART_RX_PARITY_EN
                        pfail   = perr;
`endif
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // a completing good frame overrides a same-cycle acknowledge
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            rdy        <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (rdy_clr) begin
                rdy        <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (good) begin
                if (!rdy || rdy_clr) begin
                    data_out <= sreg;
                    rdy      <= 1'b1;
                end else begin
                    overrun  <= 1'b1;
                end
            end
            if (ferr) begin
                frame_err <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (pfail) begin
                parity_err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frame-level model, busy-fall monitor.
// Honours UART_RX_PARITY_EN for 8E1 framing.
module tb_uart_receiver;

    localparam int CLKDIV = 27;
    localparam int OS     = 16;
    localparam int BITC   = CLKDIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int MID_TICKS = 8 + OS * 10;
`else
    localparam int MID_TICKS = 8 + OS * 9;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       clken   = 1'b0;
    logic       Rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic [7:0] data_out;
    logic       rdy;
    logic       Rx_busy;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       r;
        logic       fe;
        logic       ov;
        logic       pe;
    } obs_t;

    obs_t expq[$];
    obs_t m;

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk_50m  (clk_50m),
        .rst_n    (rst_n),
        .clken    (clken),
        .Rx       (Rx),
        .rdy_clr  (rdy_clr),
        .data_out (data_out),
        .rdy      (rdy),
        .Rx_busy  (Rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #10 clk_50m = ~clk_50m;

    int dcnt = 0;
    always @(posedge clk_50m) begin
        if (dcnt == CLKDIV - 1) begin
            dcnt  <= 0;
            clken <= 1'b1;
        end else begin
            dcnt  <= dcnt + 1;
            clken <= 1'b0;
        end
    end

    function automatic obs_t cur();
        obs_t o;
        o.d  = data_out;
        o.r  = rdy;
        o.fe = frame_err;
        o.ov = overrun;
`ifdef UART_RX_PARITY_EN
        o.pe = parity_err;
`else
        o.pe = 1'b0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input obs_t a, input obs_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got d=%h r=%b fe=%b ov=%b pe=%b want d=%h r=%b fe=%b ov=%b pe=%b",
                     name, a.d, a.r, a.fe, a.ov, a.pe, e.d, e.r, e.fe, e.ov, e.pe);
        end
    endtask

    task automatic check_bit(input string name, input logic a, input logic e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, a, e);
        end
    endtask

    // every end of activity (frame, glitch, reset) must match the next expectation
    logic busy_q = 1'b0;
    always @(negedge clk_50m) begin
        if (busy_q && !Rx_busy) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_end: got busy fall, want none");
            end else begin
                check("frame_end", cur(), expq.pop_front());
            end
        end
        busy_q = Rx_busy;
    end

    function automatic void m_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad);
        if (par_bad) m.pe = 1'b1;
        if (!stop_ok) m.fe = 1'b1;
        if (stop_ok && !par_bad) begin
            if (m.r) m.ov = 1'b1;
            else begin
                m.d = d;
                m.r = 1'b1;
            end
        end
        expq.push_back(m);
        // line still low after a bad stop: one false start follows
        if (!stop_ok) expq.push_back(m);
    endfunction

    function automatic void m_clear();
        m.r  = 1'b0;
        m.fe = 1'b0;
        m.ov = 1'b0;
        m.pe = 1'b0;
    endfunction

    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (BITC) @(posedge clk_50m);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_bad);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_bad);
`endif
        drive_bit(stop_b);
        drive_bit(1'b1);
    endtask

    task automatic do_clear();
        rdy_clr = 1'b1;
        @(posedge clk_50m);
        #1;
        rdy_clr = 1'b0;
        m_clear();
        check("clear", cur(), m);
    endtask

    task automatic clear_at_stop();
        int k;
        int n;
        k = 0;
        n = 0;
        while (!Rx_busy && k < 2 * BITC) begin
            @(posedge clk_50m);
            #1;
            k++;
        end
        if (!Rx_busy) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: got busy=0 want 1");
        end else begin
            while (n < MID_TICKS) begin
                @(posedge clk_50m);
                #1;
                if (clken) n++;
            end
            rdy_clr = 1'b1;
            @(posedge clk_50m);
            #1;
            rdy_clr = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         sok;
        bit         pb;
        int         k;
        m = '0;
        repeat (5) @(posedge clk_50m);
        #1;
        check("reset", cur(), m);
        check_bit("reset_busy", Rx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (BITC) @(posedge clk_50m);
        #1;

        m_frame(8'hA5, 1, 0);
        send_frame(8'hA5, 1'b1, 1'b0);
        check("single_a5", cur(), m);

        do_clear();
        expq.push_back(m);
        Rx = 1'b0;
        repeat (3 * CLKDIV) @(posedge clk_50m);
        #1;
        Rx = 1'b1;
        repeat (8 * CLKDIV) @(posedge clk_50m);
        #1;
        check("glitch", cur(), m);
        check_bit("glitch_busy", Rx_busy, 1'b0);

        m_frame(8'h3C, 0, 0);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("frame_err", cur(), m);

        do_clear();
        m_frame(8'h11, 1, 0);
        send_frame(8'h11, 1'b1, 1'b0);
        m_frame(8'h22, 1, 0);
        send_frame(8'h22, 1'b1, 1'b0);
        check("overrun", cur(), m);
        do_clear();

        m_frame(8'h01, 1, 0);
        send_frame(8'h01, 1'b1, 1'b0);
        m_clear();
        m_frame(8'h7E, 1, 0);
        fork
            send_frame(8'h7E, 1'b1, 1'b0);
            clear_at_stop();
        join
        check("clr_coincident", cur(), m);

        drive_bit(1'b0);
        drive_bit(1'b1);
        Rx = 1'b0;
        repeat (BITC / 2) @(posedge clk_50m);
        #1;
        m = '0;
        expq.push_back(m);
        rst_n = 1'b0;
        #1;
        check("reset_async", cur(), m);
        check_bit("reset_async_busy", Rx_busy, 1'b0);
        Rx = 1'b1;
        repeat (5) @(posedge clk_50m);
        #1;
        rst_n = 1'b1;
        repeat (BITC) @(posedge clk_50m);
        #1;
        m_frame(8'h55, 1, 0);
        send_frame(8'h55, 1'b1, 1'b0);
        check("after_reset_55", cur(), m);

`ifdef UART_RX_PARITY_EN
        do_clear();
        m_frame(8'h07, 1, 1);
        send_frame(8'h07, 1'b1, 1'b1);
        check("parity_err", cur(), m);
`endif

        for (int i = 0; i < 5; i++) begin
            d   = 8'($urandom);
            sok = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            pb  = ($urandom_range(0, 3) == 0);
`else
            pb  = 1'b0;
`endif
            if ($urandom_range(0, 1) == 1) do_clear();
            m_frame(d, sok, pb);
            send_frame(d, sok, pb);
        end

        k = 0;
        while (expq.size() != 0 && k < 2 * BITC) begin
            @(posedge clk_50m);
            #1;
            k++;
        end
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

UART receive path for the FPGA-to-host serial link. It is the counterpart of the existing `transmitter` and shares its 16× oversampling enable from the `baudrate` block. The block oversamples the `Rx` line, recovers 8N1 frames (8E1 when parity is compiled in), and presents each byte on a held-ready interface that downstream logic clears explicitly. It flags framing errors, overruns and, optionally, parity errors.

## Interface
Parameters:
- `DATA_BITS`, default 8: number of data bits per frame, sent LSB first.
- `OVERSAMPLE`, default 16: number of `clken` ticks per bit period. Must be a power of two, at least 8.

Ports:
- `clk_50m` input, 1 bit: system clock, 50 MHz. The block has one clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `clken` input, 1 bit: single-cycle sample enable at baud × `OVERSAMPLE`, driven by the `baudrate` block.
- `Rx` input, 1 bit: serial line; asynchronous to `clk_50m`; idles high.
- `rdy_clr` input, 1 bit: single-cycle pulse that acknowledges the current byte.
- `data_out` output, `DATA_BITS` wide: last good received byte.
- `rdy` output, 1 bit: `data_out` holds an unacknowledged byte.
- `Rx_busy` output, 1 bit: a frame is in progress (any state other than IDLE).
- `frame_err` output, 1 bit: sticky; a stop bit was sampled low.
- `overrun` output, 1 bit: sticky; a good byte arrived while `rdy` was 1.
- `parity_err` output, 1 bit: sticky; parity mismatch. Present only with `UART_RX_PARITY_EN`.

## Operation
- **Synchroniser:** `Rx` passes through a 2-flop synchroniser, reset to 1. All decisions use the synchronised value, `rx_s`.
- **Counters:**
  - Sample counter `scnt`, width log2(`OVERSAMPLE`). It advances only on `clk_50m` cycles where `clken`=1.
  - Bit counter `bcnt`, counting 0 to `DATA_BITS`-1.
- **IDLE:** on `clken` with `rx_s`=0, go to START and set `scnt`=0.
- **START:**
  - When `scnt` reaches `OVERSAMPLE`/2-1, check `rx_s`.
  - If `rx_s`=1, treat it as a glitch: return to IDLE. No flag is set.
  - If `rx_s`=0, set `scnt`=0 and `bcnt`=0, then go to DATA.
- **DATA:**
  - When `scnt` reaches `OVERSAMPLE`-1 (the bit midpoint), shift `rx_s` into the MSB of the shift register, shifting right.
  - Increment `bcnt`.
  - After bit `DATA_BITS`-1 is sampled, go to STOP (or to PARITY when the macro is defined).
- **PARITY** (macro only): sample at the midpoint and compare with the even parity of the shift register.
- **STOP:** sample at the midpoint, then always return to IDLE.
  - If `rx_s`=1 and there is no parity error, the frame is good.
  - If `rx_s`=0, set `frame_err`=1 and discard the byte.
- **Good frame:**
  - If `rdy`=0, load `data_out` and set `rdy`=1.
  - If `rdy`=1, keep `data_out` unchanged, drop the new byte, and set `overrun`=1.
- **`rdy_clr`:** clears `rdy`, `overrun`, `frame_err` and `parity_err`.
- **Same-cycle good frame and `rdy_clr`:** the good frame wins. `data_out` takes the new byte, `rdy` stays 1, and `overrun` is not set.
- **`Rx` stuck low after a frame error:** the block re-enters START from IDLE on the next `clken`. It does not wait for a rising edge.
- **Reset mid-frame:** the state returns to IDLE immediately and the partial byte is lost.

## Timing
- **Reset values:**
  - `data_out` = 0.
  - `rdy`, `Rx_busy`, `frame_err`, `overrun`, `parity_err` = 0.
  - Synchroniser flops = 1; state = IDLE.
- **Synchroniser delay:** 2 `clk_50m` cycles from an `Rx` edge to `rx_s`.
- **Flag update:** `rdy`, `data_out` and the error flags update on the `clk_50m` edge that sees the stop-bit midpoint `clken`.
- **End-to-end latency:** from the start-bit falling edge to `rdy`, about (1 + `DATA_BITS` + 0.5) bit periods plus up to 1 `clken` period plus 2 cycles. That is 9.5 bit periods for 8N1.
- **`Rx_busy`:**
  - Rises on the cycle after IDLE detects `rx_s`=0.
  - Falls in the same cycle that `rdy` or an error flag updates.
- **`rdy_clr` response:** flags clear on the next `clk_50m` edge. `rdy_clr` need not be aligned to `clken`.

## Configuration
- **`UART_RX_PARITY_EN` defined:**
  - The frame format is 8E1.
  - The PARITY state and the `parity_err` port exist.
  - A parity mismatch sets `parity_err`, discards the byte and leaves `rdy` unchanged. The stop bit is still checked.
- **`UART_RX_PARITY_EN` undefined:**
  - The frame format is 8N1.
  - The PARITY state and the `parity_err` port are removed, and DATA goes straight to STOP.

## Test plan
- **Single good byte:** `clken` every 27 cycles (115200 baud × 16); send 0xA5 as 8N1 → `rdy`=1 and `data_out`=0xA5 about 4123 cycles after the start edge; `frame_err`=0.
- **Start glitch:** drive `Rx` low for 3 `clken` ticks, then high → block returns to IDLE; `rdy`, `frame_err` and `Rx_busy` are all 0 after 8 ticks.
- **Framing error:** send 0x3C with the stop bit low → `frame_err`=1, `rdy`=0, `data_out` unchanged.
- **Overrun and clear:**
  - Send 0x11, then 0x22 without `rdy_clr` → `data_out`=0x11, `overrun`=1.
  - Pulse `rdy_clr` → `rdy`=0, `overrun`=0.
- **Clear coincident with completion:** pulse `rdy_clr` on the stop-midpoint cycle of byte 0x7E while holding byte 0x01 → `rdy`=1, `data_out`=0x7E, `overrun`=0.
- **Parity and reset** (macro defined):
  - Send 0x07 with parity bit 0 → `parity_err`=1, `rdy`=0.
  - Assert `rst_n`=0 in the middle of DATA → all outputs go to 0 asynchronously; the next frame, 0x55, is received correctly.
